// File: rtl/irrigation_pkg.sv
// Irrigation scheduler shared definitions.
// Holds the controller state encoding, the watering mode encoding and the
// default run lengths (in ticks) used as parameter defaults by the top level.
package irrigation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IRRIGATE = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  typedef enum logic {
    MODE_SPRINKLER = 1'b0,
    MODE_DRIPPER   = 1'b1
  } mode_t;

  localparam int DEFAULT_SPLINKER_TICKS = 10;
  localparam int DEFAULT_DRIPPER_TICKS  = 20;
  localparam int DEFAULT_COOLDOWN_TICKS = 2;

endpackage

// File: rtl/irrigation_zone_arbiter.sv
// Round-robin zone picker.
// Searches the request vector starting at 'pointer' and wrapping from
// ZONES-1 back to 0, returning the first requesting zone.
// Ports:
//   request     - one bit per zone, 1 = zone wants water
//   pointer     - zone index where the search starts
//   grant_index - selected zone (0 when nothing is requested)
//   grant_valid - 1 when some zone was selected
module irrigation_zone_arbiter #(
  parameter int ZONES = 4,
  parameter int IDX_W = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic [ZONES-1:0] request,
  input  logic [IDX_W-1:0] pointer,
  output logic [IDX_W-1:0] grant_index,
  output logic             grant_valid
);

  // Walk the zones in rotated order; the first hit wins and later hits are
  // ignored because grant_valid is already set.
  always_comb begin
    int cand;
    cand        = 0;
    grant_index = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < ZONES; i++) begin
      cand = (int'(pointer) + i) % ZONES;
      if (!grant_valid && request[cand]) begin
        grant_valid = 1'b1;
        grant_index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Irrigation zone scheduler.
// Waters one zone at a time, choosing zones round-robin among those that are
// dry and enabled. Each run uses either the sprinkler pump or the dripper
// valve, chosen once when the zone starts, followed by a short cooldown.
// Inconsistent tank level sensors force an error state with all valves shut.
// A separate hysteresis loop drives the tank refill valve.
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   tick                    - one-cycle time-base pulse for all countdowns
//   low/mid/high_water_level- tank sensors, 1 = water at or above level
//   zone_dry, zone_enable   - per-zone request and operator enable
//   air_humidity, low_temperature - select dripper over sprinkler when set
//   zone_valve              - one-hot (or zero) zone valve drive
//   splinker_bomb, dripper_valvule - watering method drives
//   water_supply_valvule    - tank refill valve
//   alarm, error, busy      - status flags
//   active_zone, remaining  - current zone and ticks left in current phase
// All outputs come straight from flops.
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter  int ZONES          = 4,
  parameter  int TIMER_W        = 8,
  parameter  int SPLINKER_TICKS = DEFAULT_SPLINKER_TICKS,
  parameter  int DRIPPER_TICKS  = DEFAULT_DRIPPER_TICKS,
  parameter  int COOLDOWN_TICKS = DEFAULT_COOLDOWN_TICKS,
  localparam int ZONE_W         = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               low_water_level,
  input  logic               mid_water_level,
  input  logic               high_water_level,
  input  logic [ZONES-1:0]   zone_dry,
  input  logic [ZONES-1:0]   zone_enable,
  input  logic               air_humidity,
  input  logic               low_temperature,
  output logic [ZONES-1:0]   zone_valve,
  output logic               splinker_bomb,
  output logic               dripper_valvule,
  output logic               water_supply_valvule,
  output logic               alarm,
  output logic [ZONE_W-1:0]  active_zone,
  output logic [TIMER_W-1:0] remaining,
  output logic               busy,
  output logic               error
);

  state_t             state, next_state;
  mode_t              mode, next_mode;
  logic [ZONE_W-1:0]  rr_ptr, next_ptr;
  logic [ZONE_W-1:0]  next_zone;
  logic [TIMER_W-1:0] next_remaining;
  logic [ZONES-1:0]   next_valve;
  logic               next_splinker, next_dripper, next_refill;
  logic               next_alarm, next_busy, next_error;

  logic               conflict;
  logic               active_request;
  logic [ZONE_W-1:0]  grant_index;
  logic               grant_valid;

  irrigation_zone_arbiter #(
    .ZONES (ZONES),
    .IDX_W (ZONE_W)
  ) u_arbiter (
    .request     (zone_dry & zone_enable),
    .pointer     (rr_ptr),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  // A higher sensor wet while a lower one is dry cannot happen physically,
  // so it is treated as a sensor fault.
  assign conflict       = (high_water_level & ~mid_water_level)
                        | (mid_water_level & ~low_water_level);
  assign active_request = zone_dry[active_zone] & zone_enable[active_zone];

  // Next-state and next-output logic. Outputs are computed from the next
  // state so the flops present them in the same cycle the state takes effect.
  // Abort conditions (conflict, tank empty) are tested before tick or early
  // finish so they always win.
  always_comb begin
    next_state     = state;
    next_mode      = mode;
    next_ptr       = rr_ptr;
    next_zone      = active_zone;
    next_remaining = remaining;

    unique case (state)
      ST_IDLE: begin
        next_remaining = '0;
        if (conflict) begin
          next_state = ST_ERROR;
        end else if (low_water_level && grant_valid) begin
          next_state = ST_IRRIGATE;
          next_zone  = grant_index;
          next_ptr   = (grant_index == ZONE_W'(ZONES - 1)) ? '0
                                                           : grant_index + ZONE_W'(1);
          if (mid_water_level && !air_humidity && !low_temperature) begin
            next_mode      = MODE_SPRINKLER;
            next_remaining = TIMER_W'(SPLINKER_TICKS);
          end else begin
            next_mode      = MODE_DRIPPER;
            next_remaining = TIMER_W'(DRIPPER_TICKS);
          end
        end
      end
      ST_IRRIGATE: begin
        if (conflict) begin
          next_state     = ST_ERROR;
          next_remaining = '0;
        end else if (!low_water_level) begin
          next_state     = ST_IDLE;
          next_remaining = '0;
        end else if ((tick && remaining == TIMER_W'(1)) || !active_request) begin
          next_state     = ST_COOLDOWN;
          next_remaining = TIMER_W'(COOLDOWN_TICKS);
        end else if (tick) begin
          next_remaining = remaining - TIMER_W'(1);
        end
      end
      ST_COOLDOWN: begin
        if (conflict) begin
          next_state     = ST_ERROR;
          next_remaining = '0;
        end else if (tick) begin
          if (remaining == TIMER_W'(1)) begin
            next_state     = ST_IDLE;
            next_remaining = '0;
          end else begin
            next_remaining = remaining - TIMER_W'(1);
          end
        end
      end
      ST_ERROR: begin
        next_remaining = '0;
        if (!conflict) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state     = ST_IDLE;
        next_remaining = '0;
      end
    endcase

    next_valve    = (next_state == ST_IRRIGATE) ? (ZONES'(1) << next_zone) : '0;
    next_splinker = (next_state == ST_IRRIGATE) && (next_mode == MODE_SPRINKLER);
    next_dripper  = (next_state == ST_IRRIGATE) && (next_mode == MODE_DRIPPER);
    next_busy     = (next_state == ST_IRRIGATE) || (next_state == ST_COOLDOWN);
    next_error    = (next_state == ST_ERROR);
    next_alarm    = ~mid_water_level | conflict;

    // Refill hysteresis: open below mid, close at high, otherwise hold.
    if (conflict || high_water_level) begin
      next_refill = 1'b0;
    end else if (!mid_water_level) begin
      next_refill = 1'b1;
    end else begin
      next_refill = water_supply_valvule;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= ST_IDLE;
      mode                 <= MODE_SPRINKLER;
      rr_ptr               <= '0;
      active_zone          <= '0;
      remaining            <= '0;
      zone_valve           <= '0;
      splinker_bomb        <= 1'b0;
      dripper_valvule      <= 1'b0;
      water_supply_valvule <= 1'b0;
      alarm                <= 1'b0;
      busy                 <= 1'b0;
      error                <= 1'b0;
    end else begin
      state                <= next_state;
      mode                 <= next_mode;
      rr_ptr               <= next_ptr;
      active_zone          <= next_zone;
      remaining            <= next_remaining;
      zone_valve           <= next_valve;
      splinker_bomb        <= next_splinker;
      dripper_valvule      <= next_dripper;
      water_supply_valvule <= next_refill;
      alarm                <= next_alarm;
      busy                 <= next_busy;
      error                <= next_error;
    end
  end

endmodule
